// File: rtl/strobe_pkg.sv
// Shared definitions for the multi-channel strobe generator: channel state
// encoding, default period shift and the period-to-terminal-count helper.
package strobe_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  localparam int DEF_SHIFT = 6;

  // Zero-extends a period (or phase) field and scales it to counter units.
  function automatic logic [31:0] calc_limit(input logic [31:0] value, input int unsigned shift);
    return value << shift;
  endfunction

endpackage

// File: rtl/multi_strobe_gen_if.sv
// Register-file side bundle of the strobe generator. The phase bus exists only
// when MULTI_STROBE_PHASE_EN is defined.
interface multi_strobe_gen_if #(
  parameter int CHANNELS = 4,
  parameter int CMP_W    = 8
);
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS-1:0]       oneshot;
  logic [CHANNELS*CMP_W-1:0] period;
  logic [CHANNELS-1:0]       trigger;
  logic                      sync;
  logic [CHANNELS-1:0]       strobe;
  logic [CHANNELS-1:0]       busy;
`ifdef MULTI_STROBE_PHASE_EN
  logic [CHANNELS*CMP_W-1:0] phase;

  modport master (output enable, oneshot, period, trigger, sync, phase, input strobe, busy);
  modport slave  (input enable, oneshot, period, trigger, sync, phase, output strobe, busy);
`else
  modport master (output enable, oneshot, period, trigger, sync, input strobe, busy);
  modport slave  (input enable, oneshot, period, trigger, sync, output strobe, busy);
`endif
endinterface

// File: rtl/strobe_chan.sv
// One strobe channel: counter, IDLE/RUN state and registered strobe/busy.
// A sync or an enable rising edge reloads the counter from phase_i.
module strobe_chan
  import strobe_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CMP_W = 8,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             oneshot_i,
  input  logic             trigger_i,
  input  logic             sync_i,
  input  logic [CMP_W-1:0] period_i,
  input  logic [CMP_W-1:0] phase_i,
  output logic             strobe_o,
  output logic             busy_o
);

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_RUN  = ST_RUN;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             strobe_q, strobe_d;
  logic             busy_q;
  logic             enable_q;
  logic             oneshot_q;
  logic [CNT_W-1:0] limit_s;
  logic [CNT_W-1:0] load_s;
  logic             terminal_s;

  assign limit_s    = CNT_W'(calc_limit(32'(period_i), SHIFT));
  assign load_s     = CNT_W'(calc_limit(32'(phase_i), SHIFT));
  assign terminal_s = (count_q >= limit_s);

  // Next-state decode in priority order: disable, sync/enable-rise, trigger, mode change, compare.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (sync_i || !enable_q) begin
      count_d = load_s;
      if (!oneshot_i) begin
        state_d = S_RUN;
      end else begin
        state_d = state_q;
      end
    end else if (oneshot_i && trigger_i) begin
      state_d = S_RUN;
      count_d = '0;
    end else if (oneshot_i && !oneshot_q) begin
      // Leaving periodic mode: a terminal count reached this cycle still strobes.
      state_d  = S_IDLE;
      count_d  = '0;
      strobe_d = (state_q == S_RUN) && terminal_s;
    end else if (!oneshot_i) begin
      state_d = S_RUN;
      if (terminal_s) begin
        strobe_d = 1'b1;
        count_d  = '0;
      end else begin
        count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (state_q == S_RUN) begin
      if (terminal_s) begin
        strobe_d = 1'b1;
        state_d  = S_IDLE;
        count_d  = '0;
      end else begin
        count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = '0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      enable_q  <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      strobe_q  <= strobe_d;
      busy_q    <= (state_d == S_RUN);
      enable_q  <= enable_i;
      oneshot_q <= oneshot_i;
    end
  end

  assign strobe_o = strobe_q;
  assign busy_o   = busy_q;

endmodule

// File: rtl/multi_strobe_gen.sv
// Multi-channel strobe generator top: unpacks period/phase buses and fans out
// sync to CHANNELS strobe_chan instances. Phase input via MULTI_STROBE_PHASE_EN.
module multi_strobe_gen
  import strobe_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int CMP_W    = 8,
  parameter int SHIFT    = DEF_SHIFT
) (
  input logic               clk,
  input logic               reset,
  multi_strobe_gen_if.slave bus
);

  if ((CMP_W + SHIFT > CNT_W) || (CHANNELS < 1) || (CHANNELS > 8)) begin : g_cfg_err
    $error("multi_strobe_gen: invalid CHANNELS/CNT_W/CMP_W/SHIFT combination");
  end

  logic [CHANNELS-1:0] strobe_s;
  logic [CHANNELS-1:0] busy_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CMP_W-1:0] phase_s;
`ifdef MULTI_STROBE_PHASE_EN
    assign phase_s = bus.phase[i*CMP_W +: CMP_W];
`else
    assign phase_s = '0;
`endif

    strobe_chan #(
      .CNT_W (CNT_W),
      .CMP_W (CMP_W),
      .SHIFT (SHIFT)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .enable_i  (bus.enable[i]),
      .oneshot_i (bus.oneshot[i]),
      .trigger_i (bus.trigger[i]),
      .sync_i    (bus.sync),
      .period_i  (bus.period[i*CMP_W +: CMP_W]),
      .phase_i   (phase_s),
      .strobe_o  (strobe_s[i]),
      .busy_o    (busy_s[i])
    );
  end

  assign bus.strobe = strobe_s;
  assign bus.busy   = busy_s;

endmodule

// File: tb/tb_multi_strobe_gen.sv
// Directed bench for multi_strobe_gen (4 channels, CNT_W=16, CMP_W=8, SHIFT=6).
module tb_multi_strobe_gen;

  localparam int CH  = 4;
  localparam int CMP = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_strobe_gen_if #(.CHANNELS(CH), .CMP_W(CMP)) bus ();

  multi_strobe_gen #(
    .CHANNELS (CH),
    .CNT_W    (16),
    .CMP_W    (CMP),
    .SHIFT    (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_period(input int ch, input int p);
    bus.period[ch*CMP +: CMP] = p[CMP-1:0];
  endtask

  // Ticks until strobe[ch] is seen; returns the tick index or -1.
  task automatic wait_strobe(input int ch, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (bus.strobe[ch] && n < 0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, f0, f3, first, strobes, busy_cnt;
    logic acc;
    logic [2:0] others;

    reset       = 1'b1;
    bus.enable  = '0;
    bus.oneshot = '0;
    bus.period  = '0;
    bus.trigger = '0;
    bus.sync    = 1'b0;
`ifdef MULTI_STROBE_PHASE_EN
    bus.phase   = '0;
`endif
    tick();
    tick();
    check_val("reset_strobe", 32'(bus.strobe), 32'd0);
    check_val("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Channel 0 periodic, period 1 -> limit 64, pulse every 65 cycles.
    set_period(0, 1);
    bus.enable[0] = 1'b1;
    tick();
    n = -1;
    others = '0;
    for (int i = 1; i <= 200 && n < 0; i++) begin
      tick();
      others |= bus.strobe[3:1];
      if (bus.strobe[0]) n = i;
    end
    check_val("ch0_first", 32'(n), 32'd65);
    check_val("ch0_others", 32'(others), 32'd0);
    wait_strobe(0, 200, n);
    check_val("ch0_period", 32'(n), 32'd65);

    // Channel 1 periodic, period 0 -> strobe held high.
    set_period(1, 0);
    bus.enable[1] = 1'b1;
    tick();
    tick();
    acc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      acc &= bus.strobe[1];
      tick();
    end
    check_val("ch1_const", 32'(acc), 32'd1);
    check_val("ch1_busy", 32'(bus.busy[1]), 32'd1);
    bus.enable[1] = 1'b0;
    tick();
    check_val("ch1_off_strobe", 32'(bus.strobe[1]), 32'd0);
    check_val("ch1_off_busy", 32'(bus.busy[1]), 32'd0);

    // Channel 2 one-shot, period 2 -> limit 128.
    bus.oneshot[2] = 1'b1;
    set_period(2, 2);
    bus.enable[2] = 1'b1;
    tick();
    tick();
    check_val("ch2_idle_busy", 32'(bus.busy[2]), 32'd0);
    bus.trigger[2] = 1'b1;
    tick();
    bus.trigger[2] = 1'b0;
    busy_cnt = 32'(bus.busy[2]);
    strobes = 0;
    first = -1;
    for (int i = 1; i <= 500; i++) begin
      tick();
      busy_cnt += 32'(bus.busy[2]);
      if (bus.strobe[2]) begin
        strobes++;
        if (first < 0) first = i;
      end
    end
    check_val("os_first", 32'(first), 32'd129);
    check_val("os_count", 32'(strobes), 32'd1);
    check_val("os_busy_cycles", 32'(busy_cnt), 32'd129);

    // Retrigger at count 100 restarts the count.
    bus.trigger[2] = 1'b1;
    tick();
    bus.trigger[2] = 1'b0;
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      strobes += 32'(bus.strobe[2]);
    end
    bus.trigger[2] = 1'b1;
    tick();
    bus.trigger[2] = 1'b0;
    strobes += 32'(bus.strobe[2]);
    first = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.strobe[2]) begin
        strobes++;
        if (first < 0) first = i;
      end
    end
    check_val("retrig_first", 32'(first), 32'd129);
    check_val("retrig_count", 32'(strobes), 32'd1);

    // One-shot with period 0: single strobe the cycle after the trigger.
    set_period(2, 0);
    bus.trigger[2] = 1'b1;
    tick();
    bus.trigger[2] = 1'b0;
    check_val("os0_trig_cycle", 32'(bus.strobe[2]), 32'd0);
    tick();
    check_val("os0_pulse", 32'(bus.strobe[2]), 32'd1);
    tick();
    check_val("os0_after", 32'(bus.strobe[2]), 32'd0);

    // Channels 0 and 3 periodic (limits 64 and 192), sync mid-run.
    bus.enable = '0;
    tick();
    set_period(3, 3);
    bus.enable[0] = 1'b1;
    bus.enable[3] = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) tick();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    f0 = -1;
    f3 = -1;
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (bus.strobe[0] && f0 < 0) f0 = i;
      if (bus.strobe[3] && f3 < 0) f3 = i;
    end
    check_val("sync_ch0", 32'(f0), 32'd65);
    check_val("sync_ch3", 32'(f3), 32'd193);

    // Sync landing on channel 0's terminal count suppresses that strobe.
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      acc |= bus.strobe[0];
    end
    check_val("pre_term_quiet", 32'(acc), 32'd0);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    check_val("sync_vs_term", 32'(bus.strobe[0]), 32'd0);
    wait_strobe(0, 200, n);
    check_val("sync_vs_term_next", 32'(n), 32'd65);

    // Reset while channel 2 is running at count 50.
    set_period(2, 2);
    bus.enable[2] = 1'b1;
    tick();
    bus.trigger[2] = 1'b1;
    tick();
    bus.trigger[2] = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check_val("pre_reset_busy2", 32'(bus.busy[2]), 32'd1);
    reset = 1'b1;
    tick();
    check_val("rst_run_strobe", 32'(bus.strobe), 32'd0);
    check_val("rst_run_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      acc |= bus.busy[2] | bus.strobe[2];
    end
    check_val("post_reset_idle2", 32'(acc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
